// File: rtl/task_loader_pkg.sv
// Shared types and constants for the MA injection-stream receiver (task_loader_rx).
package task_loader_pkg;

  typedef enum logic [3:0] {
    H_TEXT  = 4'd0,
    H_DATA  = 4'd1,
    H_BSS   = 4'd2,
    H_ENTRY = 4'd3,
    BIN     = 4'd4,
    D_SIZE  = 4'd5,
    D_CNT   = 4'd6,
    D_MAP   = 4'd7,
    D_TAG   = 4'd8,
    D_GRAPH = 4'd9,
    DONE    = 4'd10,
    ERR     = 4'd11
  } state_e;

  localparam int HDR_FLITS      = 4;
  localparam int BYTES_PER_WORD = 4;
  localparam int LEN_W          = 31;

  typedef struct packed {
    logic [31:0] text;
    logic [31:0] data;
    logic [31:0] bss;
    logic [31:0] entry;
  } task_hdr_t;

  // Word count of a binary; the byte sum is taken at 33 bits so a carry is never lost.
  function automatic logic [LEN_W-1:0] bin_words(input logic [31:0] text, input logic [31:0] data);
    logic [32:0] sum;
    sum = {1'b0, text} + {1'b0, data};
    return LEN_W'(sum >> $clog2(BYTES_PER_WORD));
  endfunction

endpackage

// File: rtl/task_loader_rx.sv
// Receiving end of the MA injection stream: loads task binaries, headers and the descriptor map.
// Define TASK_LOADER_RX_CHECK_EN to enable protocol checks and the sticky ERR state.
module task_loader_rx
  import task_loader_pkg::*;
#(
  parameter int FLIT_SIZE  = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int TASK_WORDS = 4096,
  parameter int MAX_TASKS  = 8,
  localparam int IDX_W     = (MAX_TASKS > 1) ? $clog2(MAX_TASKS) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  rx_i,
  output logic                  credit_o,
  input  logic [FLIT_SIZE-1:0]  data_i,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [31:0]           mem_data_o,
  input  logic                  mem_ready_i,
  output logic                  task_loaded_o,
  output logic [IDX_W-1:0]      task_idx_o,
  output logic [31:0]           entry_point_o,
  output logic [31:0]           bss_size_o,
  output logic                  map_valid_o,
  output logic [15:0]           map_addr_o,
  output logic [31:0]           map_tag_o,
  output logic [15:0]           mapper_address_o,
  output logic [15:0]           task_cnt_o,
  output logic                  done_o,
  output logic                  err_o
);

  // state   | meaning
  // H_TEXT  | header: text size (bytes)
  // H_DATA  | header: data size (bytes)
  // H_BSS   | header: bss size
  // H_ENTRY | header: entry point
  // BIN     | binary words to memory
  // D_SIZE  | descriptor: size
  // D_CNT   | descriptor: task count
  // D_MAP   | descriptor: entry PE address
  // D_TAG   | descriptor: entry tag
  // D_GRAPH | descriptor: graph flits (ignored)
  // DONE    | all binaries loaded
  // ERR     | protocol error, sticky

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d, idx_out_q, idx_out_d;
  logic [LEN_W-1:0] cnt_q, cnt_d, len;
  task_hdr_t        hdr_q, hdr_d;
  logic [15:0]      task_cnt_q, task_cnt_d, map_addr_q, map_addr_d, mapper_q, mapper_d;
  logic [31:0]      map_tag_q, map_tag_d, entry_q, entry_d, bss_q, bss_d;
  logic             map_valid_q, map_valid_d, loaded_q, loaded_d;
  logic             xfer, finish, more_tasks, cnt_last;
`ifdef TASK_LOADER_RX_CHECK_EN
  logic [31:0]      size_q, size_d;
`endif

  always_comb begin
    credit_o = 1'b1;
    case (state_q)
      BIN:       credit_o = mem_ready_i;
      DONE, ERR: credit_o = 1'b0;
      default:   credit_o = 1'b1;
    endcase
  end

  assign xfer = rx_i && credit_o;

`ifdef TASK_LOADER_RX_CHECK_EN
  assign len = bin_words(hdr_q.text, hdr_q.data);
`else
  assign len = bin_words(hdr_q.text, hdr_q.data) & LEN_W'({ADDR_WIDTH{1'b1}});
`endif

  assign more_tasks = ({1'b0, 16'(idx_q)} + 17'd1) < {1'b0, task_cnt_q};
  assign cnt_last   = (cnt_q + LEN_W'(1)) == LEN_W'(task_cnt_q);

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    hdr_d       = hdr_q;
    task_cnt_d  = task_cnt_q;
    map_addr_d  = map_addr_q;
    map_tag_d   = map_tag_q;
    mapper_d    = mapper_q;
    entry_d     = entry_q;
    bss_d       = bss_q;
    map_valid_d = 1'b0;
    loaded_d    = 1'b0;
    finish      = 1'b0;
`ifdef TASK_LOADER_RX_CHECK_EN
    size_d      = size_q;
`endif
    if (xfer) begin
      case (state_q)
        H_TEXT: begin
          hdr_d.text = 32'(data_i);
          state_d    = H_DATA;
        end
        H_DATA: begin
          hdr_d.data = 32'(data_i);
          state_d    = H_BSS;
`ifdef TASK_LOADER_RX_CHECK_EN
          if (bin_words(hdr_q.text, 32'(data_i)) > LEN_W'(TASK_WORDS)) state_d = ERR;
`endif
        end
        H_BSS: begin
          hdr_d.bss = 32'(data_i);
          state_d   = H_ENTRY;
        end
        H_ENTRY: begin
          hdr_d.entry = 32'(data_i);
          cnt_d       = '0;
          if (len == '0) finish = 1'b1;
          else state_d = BIN;
        end
        BIN: begin
          cnt_d = cnt_q + LEN_W'(1);
          if (cnt_q == len - LEN_W'(1)) finish = 1'b1;
        end
        D_SIZE: begin
`ifdef TASK_LOADER_RX_CHECK_EN
          size_d  = 32'(data_i);
`endif
          state_d = D_CNT;
        end
        D_CNT: begin
          task_cnt_d = data_i[15:0];
          cnt_d      = '0;
          state_d    = D_MAP;
`ifdef TASK_LOADER_RX_CHECK_EN
          if (32'(data_i) != size_q || data_i == '0 || 32'(data_i) > 32'(MAX_TASKS)) state_d = ERR;
`endif
        end
        D_MAP: begin
          map_addr_d = data_i[15:0];
          state_d    = D_TAG;
`ifdef TASK_LOADER_RX_CHECK_EN
          if (cnt_q == '0 && data_i[15:0] == 16'hFFFF) state_d = ERR;
`endif
        end
        D_TAG: begin
          map_tag_d   = 32'(data_i);
          map_valid_d = 1'b1;
          if (cnt_q == '0) mapper_d = map_addr_q;
          if (cnt_last) begin
            cnt_d   = '0;
            state_d = D_GRAPH;
          end else begin
            cnt_d   = cnt_q + LEN_W'(1);
            state_d = D_MAP;
          end
        end
        D_GRAPH: begin
          if (cnt_last) begin
            cnt_d = '0;
            if (task_cnt_q == 16'd1) state_d = DONE;
            else begin
              state_d = H_TEXT;
              idx_d   = IDX_W'(1);
            end
          end else begin
            cnt_d = cnt_q + LEN_W'(1);
          end
        end
        default: ;
      endcase
    end
    // Task 0 is the mapper; the descriptor follows it before any other binary.
    if (finish) begin
      loaded_d = 1'b1;
      entry_d  = hdr_d.entry;
      bss_d    = hdr_q.bss;
      cnt_d    = '0;
      if (idx_q == '0) state_d = D_SIZE;
      else if (more_tasks) begin
        state_d = H_TEXT;
        idx_d   = idx_q + IDX_W'(1);
      end else state_d = DONE;
    end
    idx_out_d = finish ? idx_q : idx_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= H_TEXT;
      idx_q       <= '0;
      idx_out_q   <= '0;
      cnt_q       <= '0;
      hdr_q       <= '0;
      task_cnt_q  <= '0;
      map_addr_q  <= '0;
      map_tag_q   <= '0;
      mapper_q    <= '0;
      entry_q     <= '0;
      bss_q       <= '0;
      map_valid_q <= 1'b0;
      loaded_q    <= 1'b0;
`ifdef TASK_LOADER_RX_CHECK_EN
      size_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      idx_out_q   <= idx_out_d;
      cnt_q       <= cnt_d;
      hdr_q       <= hdr_d;
      task_cnt_q  <= task_cnt_d;
      map_addr_q  <= map_addr_d;
      map_tag_q   <= map_tag_d;
      mapper_q    <= mapper_d;
      entry_q     <= entry_d;
      bss_q       <= bss_d;
      map_valid_q <= map_valid_d;
      loaded_q    <= loaded_d;
`ifdef TASK_LOADER_RX_CHECK_EN
      size_q      <= size_d;
`endif
    end
  end

  assign mem_we_o   = (state_q == BIN) && xfer;
  assign mem_data_o = (state_q == BIN) ? 32'(data_i) : '0;
  assign mem_addr_o = (state_q == BIN) ?
                      ADDR_WIDTH'(LEN_W'(idx_q) * LEN_W'(TASK_WORDS) + cnt_q) : '0;

  assign task_loaded_o    = loaded_q;
  assign task_idx_o       = idx_out_q;
  assign entry_point_o    = entry_q;
  assign bss_size_o       = bss_q;
  assign map_valid_o      = map_valid_q;
  assign map_addr_o       = map_addr_q;
  assign map_tag_o        = map_tag_q;
  assign mapper_address_o = mapper_q;
  assign task_cnt_o       = task_cnt_q;
  assign done_o           = (state_q == DONE);
`ifdef TASK_LOADER_RX_CHECK_EN
  assign err_o = (state_q == ERR);
`else
  assign err_o = 1'b0;
`endif

endmodule
